// File: rtl/reorder_frame_out.sv
// reorder_frame_out: output stage after the double-buffered reorder FIFO.
// Takes the ordered word stream and re-times it through a 2-entry skid buffer,
// so the pop towards the FIFO never depends combinationally on the sink.
// Each word is tagged with a frame-last flag and a frame sequence id.
// One frame is one reorder memory, i.e. 2**AW words.
module reorder_frame_out #(
  parameter int DW = 32,
  parameter int AW = 10,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] if2_dut_data,
  input  logic          if2_dut_vld,
  output logic          dut_if2_rdy,
  output logic [DW-1:0] dut_if3_data,
  output logic          dut_if3_last,
  output logic [FW-1:0] dut_if3_frame,
  output logic          dut_if3_vld,
  input  logic          if3_dut_rdy,
  output logic          frame_done
);

  localparam logic [AW-1:0] LAST_IDX = '1;

  logic [DW-1:0] data_q  [2];
  logic          last_q  [2];
  logic [FW-1:0] frame_q [2];

  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic [AW-1:0] word_cnt;
  logic [FW-1:0] frame_id;

  logic push;
  logic pop;
  logic word_is_last;

  // Ready depends only on buffer occupancy, so the upstream pop is fully registered.
  assign dut_if2_rdy  = (count < 2'd2) && !rst;
  assign dut_if3_vld  = (count != 2'd0);
  assign push         = if2_dut_vld && dut_if2_rdy;
  assign pop          = dut_if3_vld && if3_dut_rdy;
  assign word_is_last = (word_cnt == LAST_IDX);

  // Head entry drives the sink; outputs read as zero whenever nothing is buffered.
  always_comb begin
    dut_if3_data  = '0;
    dut_if3_last  = 1'b0;
    dut_if3_frame = '0;
    if (dut_if3_vld) begin
      dut_if3_data  = data_q[rd_ptr];
      dut_if3_last  = last_q[rd_ptr];
      dut_if3_frame = frame_q[rd_ptr];
    end
  end

  // Buffer storage: capture the incoming word together with its frame tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i]  <= '0;
        last_q[i]  <= 1'b0;
        frame_q[i] <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr]  <= if2_dut_data;
      last_q[wr_ptr]  <= word_is_last;
      frame_q[wr_ptr] <= frame_id;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Frame tagging counters advance only on accepted input words, so upstream gaps are harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      frame_id <= '0;
    end else if (push) begin
      word_cnt <= word_cnt + 1'b1;
      if (word_is_last) frame_id <= frame_id + 1'b1;
    end
  end

  // Pulse for one cycle after the sink takes the final word of a frame.
  always_ff @(posedge clk) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= pop && dut_if3_last;
  end

endmodule

// File: tb/tb_reorder_frame_out.sv
// tb_reorder_frame_out: directed checks of the frame output stage.
// Instance a uses AW=2 (4-word frames), instance b uses AW=1/FW=2 for id wrap.
module tb_reorder_frame_out;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] in_data_a = '0;
  logic        in_vld_a = 1'b0;
  logic        sink_rdy_a = 1'b0;
  logic        rdy_a;
  logic [31:0] data_a;
  logic        last_a;
  logic [7:0]  frame_a;
  logic        vld_a;
  logic        done_a;

  logic [31:0] in_data_b = '0;
  logic        in_vld_b = 1'b0;
  logic        sink_rdy_b = 1'b0;
  logic        rdy_b;
  logic [31:0] data_b;
  logic        last_b;
  logic [1:0]  frame_b;
  logic        vld_b;
  logic        done_b;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [7:0]  frame;
  } exp_t;

  exp_t q[$];
  int   k_a = 0;
  int   sent_a = 0;
  int   fd_seen = 0;
  logic fd_exp = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  reorder_frame_out #(.DW(32), .AW(2), .FW(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .if2_dut_data(in_data_a), .if2_dut_vld(in_vld_a), .dut_if2_rdy(rdy_a),
    .dut_if3_data(data_a), .dut_if3_last(last_a), .dut_if3_frame(frame_a),
    .dut_if3_vld(vld_a), .if3_dut_rdy(sink_rdy_a), .frame_done(done_a)
  );

  reorder_frame_out #(.DW(32), .AW(1), .FW(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .if2_dut_data(in_data_b), .if2_dut_vld(in_vld_b), .dut_if2_rdy(rdy_b),
    .dut_if3_data(data_b), .dut_if3_last(last_b), .dut_if3_frame(frame_b),
    .dut_if3_vld(vld_b), .if3_dut_rdy(sink_rdy_b), .frame_done(done_b)
  );

  // One cycle of checking on instance a, then update the expected buffer with this cycle's handshakes.
  task automatic check_a();
    logic acc2;
    logic acc3;
    n_checks++;
    if (rdy_a !== (q.size() < 2)) begin
      n_fail++;
      $display("[TB] FAIL if2_rdy: got %0b expected %0b", rdy_a, (q.size() < 2));
    end
    n_checks++;
    if (vld_a !== (q.size() != 0)) begin
      n_fail++;
      $display("[TB] FAIL if3_vld: got %0b expected %0b", vld_a, (q.size() != 0));
    end
    if (q.size() != 0) begin
      n_checks++;
      if (data_a !== q[0].data) begin
        n_fail++;
        $display("[TB] FAIL if3_data: got %0h expected %0h", data_a, q[0].data);
      end
      n_checks++;
      if (last_a !== q[0].last) begin
        n_fail++;
        $display("[TB] FAIL if3_last: got %0b expected %0b (data %0h)", last_a, q[0].last, q[0].data);
      end
      n_checks++;
      if (frame_a !== q[0].frame) begin
        n_fail++;
        $display("[TB] FAIL if3_frame: got %0d expected %0d (data %0h)", frame_a, q[0].frame, q[0].data);
      end
    end
    n_checks++;
    if (done_a !== fd_exp) begin
      n_fail++;
      $display("[TB] FAIL frame_done: got %0b expected %0b", done_a, fd_exp);
    end
    if (done_a === 1'b1) fd_seen++;
    acc3   = vld_a && sink_rdy_a;
    fd_exp = 1'b0;
    if (acc3 && q.size() != 0) begin
      fd_exp = q[0].last;
      void'(q.pop_front());
    end
    acc2 = in_vld_a && rdy_a;
    if (acc2) begin
      q.push_back('{data: in_data_a, last: ((k_a % 4) == 3), frame: 8'(k_a / 4)});
      k_a++;
      sent_a++;
    end
  endtask

  // Hold reset for n cycles while offering a word; everything must stay quiet.
  task automatic apply_reset(input int n);
    rst        = 1'b1;
    in_vld_a   = 1'b1;
    in_data_a  = 32'hDEAD_BEEF;
    sink_rdy_a = 1'b0;
    #1;
    n_checks++;
    if (rdy_a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_rdy: got %0b expected 0", rdy_a);
    end
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (rdy_a !== 1'b0 || vld_a !== 1'b0 || data_a !== 32'h0 || last_a !== 1'b0 ||
          frame_a !== 8'h0 || done_a !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rst_outputs: got rdy=%0b vld=%0b data=%0h last=%0b frame=%0d done=%0b expected all 0",
                 rdy_a, vld_a, data_a, last_a, frame_a, done_a);
      end
    end
    @(negedge clk);
    rst      = 1'b0;
    in_vld_a = 1'b0;
    q.delete();
    k_a    = 0;
    fd_exp = 1'b0;
  endtask

  // Stream n words into instance a with optional alternating valid/ready, draining the buffer at the end.
  task automatic run_a(input int n, input logic [31:0] base, input bit src_alt, input bit sink_alt,
                       input int budget);
    int cyc;
    sent_a = 0;
    cyc    = 0;
    while ((sent_a < n || q.size() != 0) && cyc < budget) begin
      @(negedge clk);
      in_vld_a   = (sent_a < n) && (!src_alt || (cyc % 2 == 0));
      in_data_a  = base + 32'(sent_a);
      sink_rdy_a = !sink_alt || (cyc % 2 == 1);
      #1;
      check_a();
      cyc++;
    end
    if (cyc >= budget) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL run_timeout: got %0d words sent expected %0d", sent_a, n);
    end
    repeat (2) begin
      @(negedge clk);
      in_vld_a   = 1'b0;
      sink_rdy_a = 1'b1;
      #1;
      check_a();
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    apply_reset(3);
  endtask

  task automatic test_single_frame();
    $display("[TB] test_single_frame");
    fd_seen = 0;
    run_a(4, 32'hA0, 1'b0, 1'b0, 20);
    n_checks++;
    if (fd_seen != 1) begin
      n_fail++;
      $display("[TB] FAIL frame_done_count: got %0d expected 1", fd_seen);
    end
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    sent_a = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_vld_a   = (sent_a < 3);
      in_data_a  = 32'hB0 + 32'(sent_a);
      sink_rdy_a = 1'b0;
      #1;
      check_a();
    end
    n_checks++;
    if (sent_a != 2) begin
      n_fail++;
      $display("[TB] FAIL bp_accepted: got %0d expected 2", sent_a);
    end
    for (int c = 0; c < 10 && (sent_a < 3 || q.size() != 0); c++) begin
      @(negedge clk);
      in_vld_a   = (sent_a < 3);
      in_data_a  = 32'hB0 + 32'(sent_a);
      sink_rdy_a = 1'b1;
      #1;
      check_a();
    end
    n_checks++;
    if (sent_a != 3 || q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL bp_release: got %0d sent %0d pending expected 3 sent 0 pending", sent_a, q.size());
    end
  endtask

  task automatic test_alternating();
    $display("[TB] test_alternating");
    apply_reset(2);
    fd_seen = 0;
    run_a(12, 32'h100, 1'b1, 1'b1, 80);
    n_checks++;
    if (fd_seen != 3) begin
      n_fail++;
      $display("[TB] FAIL alt_frames: got %0d expected 3", fd_seen);
    end
  endtask

  task automatic test_frame_wrap();
    logic [1:0] exp_frames [10];
    int sent_b;
    int recv_b;
    int cyc;
    exp_frames = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    $display("[TB] test_frame_wrap");
    sent_b = 0;
    recv_b = 0;
    cyc    = 0;
    while (recv_b < 10 && cyc < 40) begin
      @(negedge clk);
      in_vld_b   = (sent_b < 10);
      in_data_b  = 32'hE0 + 32'(sent_b);
      sink_rdy_b = 1'b1;
      #1;
      if (vld_b && sink_rdy_b) begin
        n_checks++;
        if (data_b !== 32'hE0 + 32'(recv_b) || frame_b !== exp_frames[recv_b] ||
            last_b !== (recv_b % 2 == 1)) begin
          n_fail++;
          $display("[TB] FAIL wrap_word%0d: got data=%0h frame=%0d last=%0b expected data=%0h frame=%0d last=%0b",
                   recv_b, data_b, frame_b, last_b, 32'hE0 + 32'(recv_b), exp_frames[recv_b], (recv_b % 2 == 1));
        end
        recv_b++;
      end
      if (in_vld_b && rdy_b) sent_b++;
      cyc++;
    end
    in_vld_b = 1'b0;
    n_checks++;
    if (recv_b != 10) begin
      n_fail++;
      $display("[TB] FAIL wrap_timeout: got %0d words expected 10", recv_b);
    end
  endtask

  task automatic test_reset_mid_frame();
    $display("[TB] test_reset_mid_frame");
    apply_reset(2);
    run_a(5, 32'hC0, 1'b0, 1'b0, 20);
    sent_a = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_vld_a   = (sent_a < 2);
      in_data_a  = 32'hC5 + 32'(sent_a);
      sink_rdy_a = 1'b0;
      #1;
      check_a();
    end
    n_checks++;
    if (q.size() != 2 || rdy_a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_fill: got %0d buffered rdy=%0b expected 2 buffered rdy=0", q.size(), rdy_a);
    end
    apply_reset(2);
    run_a(4, 32'hD0, 1'b0, 1'b0, 20);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_alternating();
    test_frame_wrap();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
